// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes, op legality check and
// the scheduler state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } sched_state_t;

    // True for the op codes the ALU implements; everything else is flagged as an error.
    function automatic logic alu_op_legal(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_OR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at the pointer,
// wrapping modulo NREQ, and reports a one-hot grant plus its encoded index.
// The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_idx
);

    logic w_found;
    int   w_j;

    // First requester at or after the pointer wins; nothing is granted when disabled.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (i_en && !w_found && i_req[w_j]) begin
                o_gnt[w_j] = 1'b1;
                o_idx      = ID_W'(w_j);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered ALU between NREQ requesters. A round-robin winner's
// operands are latched into the ALU input registers, the ALU's registered
// result is captured two edges later and returned on a valid/ready channel.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [3*NREQ-1:0]  req_op,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [31:0]        alu_src_a,
    output logic [31:0]        alu_src_b,
    output logic [2:0]         alu_ctrl,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy
);

    sched_state_t    r_state, w_next;
    logic [ID_W-1:0] r_ptr, w_ptr_nxt;
    logic [ID_W-1:0] w_idx;
    logic [NREQ-1:0] w_gnt;
    logic            w_accept;
    logic [2:0]      w_op;
    logic [31:0]     w_a, w_b;
    logic            w_legal;

    logic [31:0]     r_src_a, r_src_b;
    logic [2:0]      r_ctrl;
    logic            r_err_q;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_result;
    logic            r_zero, r_err;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .i_en  (r_state == S_IDLE),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_accept  = |w_gnt;
    assign w_op      = req_op[3*int'(w_idx) +: 3];
    assign w_a       = req_a[32*int'(w_idx) +: 32];
    assign w_b       = req_b[32*int'(w_idx) +: 32];
    assign w_legal   = alu_op_legal(w_op);
    assign w_ptr_nxt = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: one cycle each in EXEC and CAPT, RESP waits for the handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_CAPT;
            S_CAPT:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Accept path: latch winner, advance pointer, load ALU inputs (zeros for an illegal op).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_src_a <= '0;
            r_src_b <= '0;
            r_ctrl  <= ALU_ADD;
            r_err_q <= 1'b0;
        end else if (w_accept) begin
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_idx;
            r_err_q <= !w_legal;
            r_src_a <= w_legal ? w_a  : '0;
            r_src_b <= w_legal ? w_b  : '0;
            r_ctrl  <= w_legal ? w_op : ALU_ADD;
        end
    end

    // Capture path: sample the ALU's registered result; an illegal op reports 0 / not-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_CAPT) begin
            r_result <= r_err_q ? '0   : alu_result;
            r_zero   <= r_err_q ? 1'b0 : alu_zero;
            r_err    <= r_err_q;
        end
    end

    assign req_ready  = w_gnt & {NREQ{rst_n}};
    assign alu_src_a  = r_src_a;
    assign alu_src_b  = r_src_b;
    assign alu_ctrl   = r_ctrl;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler with a registered add/sub/or ALU on the alu_* ports.
// Requester drivers replay per-requester job queues; expected responses are
// queued by the test and checked in order at each response handshake.
module tb_alu_scheduler;

    localparam int NREQ = 2;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } job_t;

    typedef struct {
        logic [31:0] id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [31:0]       alu_src_a, alu_src_b;
    logic [2:0]        alu_ctrl;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    logic              busy;

    int total = 0;
    int bad   = 0;

    job_t jq0[$];
    job_t jq1[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_scheduler #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Registered ALU: result updates on the clock edge, zero flag follows the result.
    always_ff @(posedge clk) begin
        case (alu_ctrl)
            3'b000:  alu_result <= alu_src_a + alu_src_b;
            3'b001:  alu_result <= alu_src_a - alu_src_b;
            3'b010:  alu_result <= alu_src_a | alu_src_b;
            default: alu_result <= 32'h0;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] res, input logic z, input logic e);
        exp_t x;
        x.id = 32'(id); x.result = res; x.zero = z; x.err = e;
        sb.push_back(x);
    endtask

    function automatic job_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        job_t j;
        j.op = op; j.a = a; j.b = b;
        return j;
    endfunction

    // Requester drivers: hold the head job valid until it is accepted, then move on.
    initial begin
        logic [NREQ-1:0] acc;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (acc[0] && jq0.size() > 0) void'(jq0.pop_front());
            if (acc[1] && jq1.size() > 0) void'(jq1.pop_front());
            if (jq0.size() > 0) begin
                req_valid[0] = 1'b1; req_op[2:0] = jq0[0].op;
                req_a[31:0] = jq0[0].a; req_b[31:0] = jq0[0].b;
            end else req_valid[0] = 1'b0;
            if (jq1.size() > 0) begin
                req_valid[1] = 1'b1; req_op[5:3] = jq1[0].op;
                req_a[63:32] = jq1[0].a; req_b[63:32] = jq1[0].b;
            end else req_valid[1] = 1'b0;
        end
    end

    // Response monitor: every handshake is checked against the next expected entry.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got id=%0d result=0x%0h expected no response",
                             rsp_id, rsp_result);
                end else begin
                    x = sb.pop_front();
                    chk("rsp_id",     32'(rsp_id), x.id);
                    chk("rsp_result", rsp_result,  x.result);
                    chk("rsp_zero",   32'(rsp_zero), 32'(x.zero));
                    chk("rsp_err",    32'(rsp_err),  32'(x.err));
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (jq0.size() == 0 && jq1.size() == 0 && sb.size() == 0 && !busy && req_valid == '0)
                done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", nm, sb.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_busy",   32'(busy), 0);
        chk("rst_valid",  32'(rsp_valid), 0);
        chk("rst_id",     32'(rsp_id), 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero",   32'(rsp_zero), 0);
        chk("rst_err",    32'(rsp_err), 0);
        chk("rst_src_a",  alu_src_a, 0);
        chk("rst_src_b",  alu_src_b, 0);
        chk("rst_ctrl",   32'(alu_ctrl), 0);
        chk("rst_ready",  32'(req_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add 5+7 with latency check
        jq0.push_back(mk(3'b000, 32'd5, 32'd7));
        push_exp(0, 32'd12, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_ready", 32'(req_ready), 32'b01);
        chk("add_busy_idle", 32'(busy), 0);
        @(negedge clk);
        chk("add_busy_exec", 32'(busy), 1);
        chk("add_src_a", alu_src_a, 32'd5);
        chk("add_src_b", alu_src_b, 32'd7);
        chk("add_ctrl",  32'(alu_ctrl), 32'b000);
        chk("add_valid_exec", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("add_valid_capt", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("add_valid_resp", 32'(rsp_valid), 1);
        wait_idle("add");

        // Zero flag: req1 sub equal operands
        jq1.push_back(mk(3'b001, 32'h1234, 32'h1234));
        push_exp(1, 32'd0, 1'b1, 1'b0);
        wait_idle("zero");

        // Contention: both requesters valid continuously, grants alternate 0,1,0,1
        jq0.push_back(mk(3'b000, 32'd1, 32'd1));
        jq0.push_back(mk(3'b000, 32'd1, 32'd1));
        jq1.push_back(mk(3'b010, 32'hF0, 32'h0F));
        jq1.push_back(mk(3'b010, 32'hF0, 32'h0F));
        push_exp(0, 32'd2,  1'b0, 1'b0);
        push_exp(1, 32'hFF, 1'b0, 1'b0);
        push_exp(0, 32'd2,  1'b0, 1'b0);
        push_exp(1, 32'hFF, 1'b0, 1'b0);
        wait_idle("contention");

        // Backpressure: response held for 5 cycles with a competing request pending
        rsp_ready = 1'b0;
        jq0.push_back(mk(3'b000, 32'd3, 32'd4));
        jq1.push_back(mk(3'b010, 32'd1, 32'd2));
        push_exp(0, 32'd7, 1'b0, 1'b0);
        push_exp(1, 32'd3, 1'b0, 1'b0);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("bp_reach_resp", 32'(seen), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid",  32'(rsp_valid), 1);
            chk("bp_result", rsp_result, 32'd7);
            chk("bp_id",     32'(rsp_id), 0);
            chk("bp_ready",  32'(req_ready), 0);
            chk("bp_src_a",  alu_src_a, 32'd3);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_busy",  32'(busy), 0);
        chk("bp_idle_ready", 32'(req_ready), 32'b10);
        wait_idle("backpressure");

        // Illegal op 101: ALU loaded with zeros, error reported
        jq0.push_back(mk(3'b101, 32'd9, 32'd9));
        push_exp(0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ill_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        chk("ill_ctrl",  32'(alu_ctrl), 32'b000);
        chk("ill_src_a", alu_src_a, 32'd0);
        chk("ill_src_b", alu_src_b, 32'd0);
        wait_idle("illegal");

        // Reset pulse in EXEC: in-flight op dropped, pointer back to 0
        jq0.push_back(mk(3'b000, 32'd6, 32'd6));
        @(negedge clk);
        chk("rp_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        chk("rp_busy_exec", 32'(busy), 1);
        jq1.push_back(mk(3'b001, 32'd10, 32'd3));
        rst_n = 1'b0;
        #1;
        chk("rp_busy",   32'(busy), 0);
        chk("rp_valid",  32'(rsp_valid), 0);
        chk("rp_src_a",  alu_src_a, 0);
        chk("rp_ctrl",   32'(alu_ctrl), 0);
        chk("rp_id",     32'(rsp_id), 0);
        @(negedge clk);
        chk("rp_ready_forced", 32'(req_ready), 0);
        chk("rp_valid2", 32'(rsp_valid), 0);
        jq0.push_back(mk(3'b000, 32'd6, 32'd6));
        push_exp(0, 32'd12, 1'b0, 1'b0);
        push_exp(1, 32'd7,  1'b0, 1'b0);
        @(negedge clk);
        chk("rp_ready_forced2", 32'(req_ready), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rp_ptr0_grant", 32'(req_ready), 32'b01);
        wait_idle("reset");

        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequences and shares the single registered ALU (add/sub/or, result registered on `clk`) between `NREQ` requesters. Arbitrates round-robin, drives the ALU operand/control inputs from holding registers, waits for the ALU's registered result, and returns result, zero flag and requester ID over a valid/ready response channel. Sits between the core's execute-stage requesters (main datapath, branch compare, address calc) and the ALU instance.

## Interface
- `NREQ`, 2, number of requesters (2..4).
- `ID_W`, `$clog2(NREQ)`, width of requester ID (derived localparam, minimum 1).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_op`  in  3*NREQ  packed ALU control per requester (slice i = bits 3i+2:3i).
- `req_a`, `req_b`  in  32*NREQ  packed operands per requester.
- `alu_src_a`, `alu_src_b`  out  32  to ALU `SrcA`/`SrcB`.
- `alu_ctrl`  out  3  to ALU `ALUControl`.
- `alu_result`  in  32  from ALU `result`.
- `alu_zero`  in  1  from ALU `zero`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  ID_W  index of requester served.
- `rsp_result`  out  32  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_err`  out  1  op code was unsupported.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Legal ops: 000 add, 001 sub, 010 or. 011..111 are illegal.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE: if any `req_valid`, round-robin arbiter selects winner w; `req_ready[w]`=1 combinationally; on the edge: latch w into `rsp_id`, load `alu_src_a/b`/`alu_ctrl` from w's slice, → EXEC. Illegal op: load 0/0/000, set `err_q`, still → EXEC.
- EXEC: ALU inputs held stable; ALU registers result on this edge; → CAPT.
- CAPT: on edge, `rsp_result`←`alu_result`, `rsp_zero`←`alu_zero`, `rsp_err`←`err_q`. If `err_q`: result forced 0, zero forced 0. → RESP.
- RESP: `rsp_valid`=1, all `rsp_*` stable until `rsp_valid & rsp_ready` at an edge → IDLE, `rsp_valid` drops.
- `req_ready` is 0 outside IDLE; requests wait (requester must hold valid and payload stable).
- Round-robin: pointer p (reset 0). Search order p, p+1, …, wrapping mod NREQ. After a grant to w, p ← (w+1) mod NREQ. Pointer is unchanged when there is no grant.
- ALU inputs hold their last values in CAPT, RESP and IDLE; they change only on an accept edge.

## Timing
- Reset values: state IDLE, p=0, `alu_src_a/b`=0, `alu_ctrl`=000, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0. `req_ready` forced 0 while `rst_n`=0.
- Accept at edge E0 → `rsp_valid` high after E2 (2-cycle latency). Earliest next accept is the edge after the IDLE re-entry, so back-to-back ops take ≥4 cycles each.
- `rsp_ready` held high in RESP: handshake at E3, IDLE during cycle E3–E4, next accept at E4.
- A request that drops `req_valid` before acceptance is lost; this is not an error.
- Reset asserted mid-operation: in-flight op is discarded, no response is issued, pointer returns to 0.
- `rsp_ready` outside RESP is ignored.

## Structure
- Shared package `alu_pkg`: op code constants `ALU_ADD`=3'b000, `ALU_SUB`=3'b001, `ALU_OR`=3'b010; `alu_op_legal` function; scheduler state enum.
- One sub-module, `rr_arbiter` (parameter NREQ): inputs request vector, pointer, enable; outputs one-hot grant and encoded index. Pointer update lives in `alu_scheduler`.
- Bench instantiates the real ALU connected to the `alu_*` ports.

## Test plan
- Single add: req0 op 000, a=5, b=7 → `req_ready[0]` same cycle; `rsp_valid` 2 edges later, `rsp_result`=12, `rsp_zero`=0, `rsp_id`=0, `rsp_err`=0.
- Zero flag: req1 sub with a=b=0x1234 → `rsp_result`=0, `rsp_zero`=1, `rsp_id`=1.
- Contention: req0 and req1 both valid continuously, req0 add 1+1, req1 or 0xF0|0x0F → grants alternate 0,1,0,1; results 2 and 0xFF; each response held until `rsp_ready`.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready` all 0, no new ALU load; release → handshake and return to IDLE.
- Illegal op 101 → `rsp_err`=1, `rsp_result`=0, `rsp_zero`=0, `alu_ctrl`=000.
- Reset pulse in EXEC → all outputs at reset values, no `rsp_valid`; next request is served from pointer 0.
